cpu_accel_port: RTL
===================

# cpu_accel_port

Accelerator-side responder for the CPU's `accel_*` port: the block the CPU reads from and writes to when it executes accelerator I/O instructions. It decodes `accel_id`, buffers CPU writes in a TX FIFO drained by a downstream valid/ready consumer (plotting pipeline), and buffers upstream valid/ready data in an RX FIFO for CPU reads. A status register reports fill levels and provides flush control.

## Interface
- `DATA_WIDTH`, 16, width of accel data and stream data
- `ID_WIDTH`, 4, width of `accel_id`
- `DEPTH`, 16, entries per FIFO; power of two, 2..128
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `accel_id`  in  ID_WIDTH  target select from CPU
- `accel_can_read`  out  1  CPU may read this cycle
- `accel_can_write`  out  1  CPU may write this cycle
- `accel_read_enable`  in  1  CPU read strobe
- `accel_read_data`  out  DATA_WIDTH  read value, valid same cycle as strobe
- `accel_write_enable`  in  1  CPU write strobe
- `accel_write_data`  in  DATA_WIDTH  write value
- `out_valid`  out  1  TX FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data`
- `out_data`  out  DATA_WIDTH  TX FIFO head
- `in_valid`  in  1  producer offers `in_data`
- `in_ready`  out  1  RX FIFO not full
- `in_data`  in  DATA_WIDTH  producer data

## Operation
- ID map: 0 = data (read pops RX, write pushes TX); 1 = status/control; 2..2^ID_WIDTH-1 = null target.
- `accel_can_read`: id 0 -> RX non-empty; id 1 and null -> 1. `accel_can_write`: id 0 -> TX not full; id 1 and null -> 1. Purely combinational from `accel_id` and registered counts.
- `accel_read_data`: id 0 with RX non-empty -> RX head (first-word-fall-through); id 1 -> `{rx_count[7:0], tx_count[7:0]}`; otherwise 0.
- Id 0 read with `accel_read_enable`=1 and RX non-empty pops RX at the edge. Read with RX empty: no pop, data 0.
- Id 0 write with `accel_write_enable`=1 and TX not full pushes `accel_write_data`. Write with TX full: dropped, no state change.
- Id 1 write: bit0=1 flushes TX, bit1=1 flushes RX (count and pointers to 0); other bits ignored. Null-target writes discarded.
- Read and write strobes in the same cycle are handled independently.
- TX: `out_valid` = tx_count != 0; pop when `out_valid && out_ready`. `out_data` = 0 when `out_valid`=0.
- RX: `in_ready` = rx_count != DEPTH; push when `in_valid && in_ready`.
- Counts are $clog2(DEPTH)+1 bits; pointers $clog2(DEPTH) bits, wrap modulo DEPTH.

## Timing
- Reset (async assert, released on clock): counts and pointers 0; `out_valid`=0, `out_data`=0, `in_ready`=1; `accel_can_read`=0 only when `accel_id`=0, else 1; `accel_can_write`=1.
- CPU write to TX -> `out_valid`=1 the next cycle; stream push to RX -> `accel_can_read` (id 0) = 1 the next cycle.
- Full/empty decisions use registered counts: push into a full FIFO is refused even if a pop occurs in the same cycle; pop from an empty FIFO is refused even if a push occurs in the same cycle.
- Simultaneous push and pop on a partially filled FIFO: count unchanged, both take effect.
- Flush in the same cycle as push/pop on that FIFO: flush wins, count becomes 0, pushed word lost.
- Reset mid-transfer: all buffered data discarded, state as above.
- Status read reflects counts before the current edge's updates.

## Test plan
- After reset, id=0: `accel_can_read`=0, `accel_can_write`=1, `in_ready`=1, `out_valid`=0; id=1 read -> 0x0000; id=5 read -> 0.
- CPU writes 0x0001,0x0002,0x0003 to id 0 with `out_ready`=0 -> status 0x0003; then `out_ready`=1 -> `out_data` 1,2,3 on consecutive cycles, `out_valid` low after.
- Write DEPTH+1 words, `out_ready`=0 -> `accel_can_write`=0 after DEPTH; extra word dropped; drain yields exactly DEPTH words in order.
- Producer pushes 0x002A, 0xBEEF -> CPU reads id 0 return 0x002A then 0xBEEF; third read with RX empty returns 0, count stays 0.
- RX full, `in_valid`=1 and CPU pop same cycle -> `in_ready`=0 that cycle, count DEPTH-1 after; TX at count 3 with push and pop same cycle -> count stays 3.
- Fill TX 4 and RX 2, write 0x0003 to id 1 with a simultaneous `in_valid` push -> status 0x0000 next cycle, `out_valid`=0; assert `rst` mid-stream -> outputs immediately at reset values.

Source files
------------

// File: rtl/cpu_accel_port.sv
// CPU accelerator-port responder: decodes accel_id, buffers CPU writes in a TX FIFO
// toward a valid/ready consumer and upstream stream data in an RX FIFO for CPU reads.
module cpu_accel_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   accel_id,
  output logic                  accel_can_read,
  output logic                  accel_can_write,
  input  logic                  accel_read_enable,
  output logic [DATA_WIDTH-1:0] accel_read_data,
  input  logic                  accel_write_enable,
  input  logic [DATA_WIDTH-1:0] accel_write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]         tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0]         tx_count, rx_count;

  logic is_data, is_ctrl;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_flush, rx_flush;
  logic [15:0] status;

  assign is_data  = (accel_id == '0);
  assign is_ctrl  = (accel_id == ID_WIDTH'(1));

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL);

  // Full/empty decisions come only from registered counts, never from same-cycle traffic.
  assign tx_push  = is_data & accel_write_enable & ~tx_full;
  assign tx_pop   = ~tx_empty & out_ready;
  assign rx_push  = in_valid & ~rx_full;
  assign rx_pop   = is_data & accel_read_enable & ~rx_empty;
  assign tx_flush = is_ctrl & accel_write_enable & accel_write_data[0];
  assign rx_flush = is_ctrl & accel_write_enable & accel_write_data[1];

  assign status = {8'(rx_count), 8'(tx_count)};

  assign accel_can_read  = is_data ? ~rx_empty : 1'b1;
  assign accel_can_write = is_data ? ~tx_full  : 1'b1;
  assign out_valid       = ~tx_empty;
  assign out_data        = tx_empty ? '0 : tx_mem[tx_rd];
  assign in_ready        = ~rx_full;

  always_comb begin
    accel_read_data = '0;
    if (is_data && !rx_empty)
      accel_read_data = rx_mem[rx_rd];
    else if (is_ctrl)
      accel_read_data = DATA_WIDTH'(status);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= accel_write_data;
    if (rx_push) rx_mem[rx_wr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_count <= '0;
      tx_wr    <= '0;
      tx_rd    <= '0;
    end else if (tx_flush) begin
      tx_count <= '0;
      tx_wr    <= '0;
      tx_rd    <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
    end else if (rx_flush) begin
      rx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

endmodule
